// File: rtl/messbauer_pkg.sv
// Shared definitions for the Messbauer velocity channel detector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package messbauer_pkg;

    // Lock/slope tracking states of the detector.
    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_RISING  = 2'd1,
        ST_FALLING = 2'd2
    } state_e;

    // Value reported on the direction output.
    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Default width of the velocity code.
    localparam int DEFAULT_VALUE_W = 8;

endpackage

// File: rtl/messbauer_slope_classifier.sv
// Classifies the step between two velocity codes into up/down/hold/fault.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, qualified by the caller.
// Ports: value_i/prev_i current and previous code; step_up_o, step_down_o
//        (0<|delta|<=MAX_STEP), hold_o (delta==0), fault_o (|delta|>MAX_STEP).
module messbauer_slope_classifier #(
    parameter int VALUE_W  = 8,
    parameter int MAX_STEP = 2
) (
    input  logic [VALUE_W-1:0] value_i,
    input  logic [VALUE_W-1:0] prev_i,
    output logic               step_up_o,
    output logic               step_down_o,
    output logic               hold_o,
    output logic               fault_o
);

    localparam logic [VALUE_W:0] MAX_MAG = (VALUE_W+1)'(MAX_STEP);

    logic [VALUE_W:0] val_ext;
    logic [VALUE_W:0] prev_ext;
    logic             neg;
    logic [VALUE_W:0] mag;

    assign val_ext  = {1'b0, value_i};
    assign prev_ext = {1'b0, prev_i};

    // Sign of the extended difference, magnitude taken in the positive order
    // so no signed negation is needed.
    assign neg = value_i < prev_i;
    assign mag = neg ? (prev_ext - val_ext) : (val_ext - prev_ext);

    assign hold_o      = (mag == '0);
    assign fault_o     = (mag > MAX_MAG);
    assign step_up_o   = !neg && !hold_o && !fault_o;
    assign step_down_o = neg && !fault_o;

endmodule

// File: rtl/messbauer_velocity_channel_detector.sv
// Tracks the triangular velocity code and maps each sample to a channel
// (rising slope -> low half, falling slope -> mirrored high half).
// Latency: 1 cycle from a valid sample to registered outputs; no backpressure.
// Ports: clk/areset, sample_valid/sample_value in; channel, channel_valid,
//        direction, period_start, slope_error, locked, period_count out.
module messbauer_velocity_channel_detector
    import messbauer_pkg::*;
#(
    parameter int VALUE_W    = DEFAULT_VALUE_W,
    parameter int LOCK_COUNT = 4,
    parameter int MAX_STEP   = 2,
    parameter int PERIOD_W   = 16
) (
    input  logic                clk,
    input  logic                areset,
    input  logic                sample_valid,
    input  logic [VALUE_W-1:0]  sample_value,
    output logic [VALUE_W:0]    channel,
    output logic                channel_valid,
    output logic                direction,
    output logic                period_start,
    output logic                slope_error,
    output logic                locked,
    output logic [PERIOD_W-1:0] period_count
);

    localparam int              CHANNEL_W = VALUE_W + 1;
    localparam int              CNT_W     = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_COUNT);

    state_e                 state_q, state_d;
    logic                   have_prev_q, have_prev_d;
    logic [VALUE_W-1:0]     prev_q, prev_d;
    logic [CNT_W-1:0]       lock_cnt_q, lock_cnt_d;
    logic                   last_up_q, last_up_d;
    logic [CHANNEL_W-1:0]   channel_q, channel_d;
    logic                   channel_valid_q, channel_valid_d;
    logic                   direction_q, direction_d;
    logic                   period_start_q, period_start_d;
    logic                   slope_error_q, slope_error_d;
    logic [PERIOD_W-1:0]    period_count_q, period_count_d;

    logic step_up, step_down, hold, fault;
    logic [CNT_W-1:0]       cnt_next;
    logic                   dir_now;
    logic                   emit;

    messbauer_slope_classifier #(
        .VALUE_W  (VALUE_W),
        .MAX_STEP (MAX_STEP)
    ) u_classifier (
        .value_i     (sample_value),
        .prev_i      (prev_q),
        .step_up_o   (step_up),
        .step_down_o (step_down),
        .hold_o      (hold),
        .fault_o     (fault)
    );

    always_comb begin
        state_d         = state_q;
        have_prev_d     = have_prev_q;
        prev_d          = prev_q;
        lock_cnt_d      = lock_cnt_q;
        last_up_d       = last_up_q;
        channel_d       = channel_q;
        channel_valid_d = 1'b0;
        direction_d     = direction_q;
        period_start_d  = 1'b0;
        slope_error_d   = 1'b0;
        period_count_d  = period_count_q;
        cnt_next        = '0;
        dir_now         = direction_q;
        emit            = 1'b0;

        if (sample_valid) begin
            prev_d      = sample_value;
            have_prev_d = 1'b1;
            // The first sample after reset only seeds prev.
            if (have_prev_q) begin
                unique case (state_q)
                    ST_ACQUIRE: begin
                        if (hold || fault) begin
                            lock_cnt_d = '0;
                        end else begin
                            // With a zero count the +1 path also yields 1, so
                            // a stale last_up_q is harmless.
                            cnt_next   = (step_up == last_up_q) ? lock_cnt_q + CNT_W'(1)
                                                                : CNT_W'(1);
                            lock_cnt_d = cnt_next;
                            last_up_d  = step_up;
                            if (cnt_next == LOCK_TGT) begin
                                state_d    = step_up ? ST_RISING : ST_FALLING;
                                lock_cnt_d = '0;
                                dir_now    = step_up ? DIR_FWD : DIR_REV;
                                emit       = 1'b1;
                            end
                        end
                    end
                    ST_RISING, ST_FALLING: begin
                        if (fault) begin
                            // Current sample becomes prev, so reacquisition
                            // starts counting from the very next sample.
                            state_d       = ST_ACQUIRE;
                            lock_cnt_d    = '0;
                            slope_error_d = 1'b1;
                        end else begin
                            dir_now = (state_q == ST_FALLING) ? DIR_REV : DIR_FWD;
                            if (step_down) begin
                                dir_now = DIR_REV;
                            end else if (step_up) begin
                                dir_now = DIR_FWD;
                                if (state_q == ST_FALLING) begin
                                    period_start_d = 1'b1;
                                    period_count_d = period_count_q + PERIOD_W'(1);
                                end
                            end
                            state_d = (dir_now == DIR_REV) ? ST_FALLING : ST_RISING;
                            emit    = 1'b1;
                        end
                    end
                    default: state_d = ST_ACQUIRE;
                endcase
            end
        end

        if (emit) begin
            channel_valid_d = 1'b1;
            direction_d     = dir_now;
            // Falling mapping is (2^CHANNEL_W-1) - value, i.e. bitwise inversion.
            channel_d       = (dir_now == DIR_REV) ? ~{1'b0, sample_value}
                                                   : {1'b0, sample_value};
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q         <= ST_ACQUIRE;
            have_prev_q     <= 1'b0;
            prev_q          <= '0;
            lock_cnt_q      <= '0;
            last_up_q       <= 1'b0;
            channel_q       <= '0;
            channel_valid_q <= 1'b0;
            direction_q     <= 1'b0;
            period_start_q  <= 1'b0;
            slope_error_q   <= 1'b0;
            period_count_q  <= '0;
        end else begin
            state_q         <= state_d;
            have_prev_q     <= have_prev_d;
            prev_q          <= prev_d;
            lock_cnt_q      <= lock_cnt_d;
            last_up_q       <= last_up_d;
            channel_q       <= channel_d;
            channel_valid_q <= channel_valid_d;
            direction_q     <= direction_d;
            period_start_q  <= period_start_d;
            slope_error_q   <= slope_error_d;
            period_count_q  <= period_count_d;
        end
    end

    assign channel       = channel_q;
    assign channel_valid = channel_valid_q;
    assign direction     = direction_q;
    assign period_start  = period_start_q;
    assign slope_error   = slope_error_q;
    assign locked        = (state_q != ST_ACQUIRE);
    assign period_count  = period_count_q;

endmodule

// File: tb/tb_messbauer_velocity_channel_detector.sv
// Self-checking bench: directed waveform scenarios plus a random walk,
// compared cycle by cycle against a sample-level behavioural model.
// Period counter narrowed to 8 bits so the wrap scenario stays short.
module tb_messbauer_velocity_channel_detector;

    localparam int VW   = 8;
    localparam int LOCK = 4;
    localparam int MAXS = 2;
    localparam int PW   = 8;
    localparam int CMAX = (1 << (VW + 1)) - 1;

    logic          clk;
    logic          areset;
    logic          sample_valid;
    logic [VW-1:0] sample_value;
    logic [VW:0]   channel;
    logic          channel_valid;
    logic          direction;
    logic          period_start;
    logic          slope_error;
    logic          locked;
    logic [PW-1:0] period_count;

    messbauer_velocity_channel_detector #(
        .VALUE_W    (VW),
        .LOCK_COUNT (LOCK),
        .MAX_STEP   (MAXS),
        .PERIOD_W   (PW)
    ) dut (
        .clk           (clk),
        .areset        (areset),
        .sample_valid  (sample_valid),
        .sample_value  (sample_value),
        .channel       (channel),
        .channel_valid (channel_valid),
        .direction     (direction),
        .period_start  (period_start),
        .slope_error   (slope_error),
        .locked        (locked),
        .period_count  (period_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: tracks whether the waveform is followed, which way
    // it is heading, and how many consistent steps have been seen.
    bit m_have, m_locked, m_dir, m_up;
    int m_prev, m_run, m_pc;
    int e_ch, e_cv, e_dir, e_ps, e_se;
    int wraps_seen;

    task automatic model_reset();
        m_have = 0; m_locked = 0; m_dir = 0; m_up = 0;
        m_prev = 0; m_run = 0; m_pc = 0;
        e_ch = 0; e_cv = 0; e_dir = 0; e_ps = 0; e_se = 0;
    endtask

    task automatic model_step(input bit v, input int val);
        int d, ad;
        bit up;
        e_cv = 0; e_ps = 0; e_se = 0;
        if (!v) return;
        if (!m_have) begin
            m_have = 1;
            m_prev = val;
            return;
        end
        d  = val - m_prev;
        ad = (d < 0) ? -d : d;
        m_prev = val;
        if (!m_locked) begin
            if (d != 0 && ad <= MAXS) begin
                up    = (d > 0);
                m_run = (m_run > 0 && up == m_up) ? m_run + 1 : 1;
                m_up  = up;
                if (m_run == LOCK) begin
                    m_locked = 1;
                    m_run    = 0;
                    m_dir    = !up;
                    e_cv = 1; e_dir = m_dir;
                    e_ch = m_dir ? CMAX - val : val;
                end
            end else begin
                m_run = 0;
            end
        end else if (ad > MAXS) begin
            e_se = 1;
            m_locked = 0;
            m_run = 0;
        end else begin
            if (d > 0 && m_dir) begin
                m_dir = 0;
                e_ps  = 1;
                m_pc  = (m_pc + 1) % (1 << PW);
                if (m_pc == 0) wraps_seen++;
            end else if (d < 0) begin
                m_dir = 1;
            end
            e_cv = 1; e_dir = m_dir;
            e_ch = m_dir ? CMAX - val : val;
        end
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, ".cv"},  32'(channel_valid), 32'(e_cv));
        check({ctx, ".ps"},  32'(period_start),  32'(e_ps));
        check({ctx, ".se"},  32'(slope_error),   32'(e_se));
        check({ctx, ".lk"},  32'(locked),        32'(m_locked));
        check({ctx, ".pc"},  32'(period_count),  32'(m_pc));
        check({ctx, ".ch"},  32'(channel),       32'(e_ch));
        check({ctx, ".dir"}, 32'(direction),     32'(e_dir));
    endtask

    task automatic check_zero(input string ctx);
        check({ctx, ".ch0"},  32'(channel),       0);
        check({ctx, ".cv0"},  32'(channel_valid), 0);
        check({ctx, ".dir0"}, 32'(direction),     0);
        check({ctx, ".ps0"},  32'(period_start),  0);
        check({ctx, ".se0"},  32'(slope_error),   0);
        check({ctx, ".lk0"},  32'(locked),        0);
        check({ctx, ".pc0"},  32'(period_count),  0);
    endtask

    // One clock: drive, let the DUT register it, compare #1 after the edge.
    task automatic cyc(input string ctx, input bit v, input int val);
        sample_valid = v;
        sample_value = VW'(val);
        model_step(v, val);
        @(posedge clk);
        #1;
        compare_all(ctx);
    endtask

    int cur;
    int nxt;

    initial begin
        wraps_seen   = 0;
        sample_valid = 1'b0;
        sample_value = '0;
        areset       = 1'b1;
        model_reset();
        #3;
        check_zero("reset");
        @(posedge clk);
        #1;
        areset = 1'b0;

        // Rising ramp: lock on the 4th step, channel == value.
        for (int i = 0; i <= 255; i++) cyc("ramp_up", 1'b1, i);
        check("lock_after_ramp", 32'(locked), 1);
        check("ramp_top_ch", 32'(channel), 255);

        // Falling ramp then rise again: mirrored channels and a period start.
        for (int i = 254; i >= 0; i--) cyc("ramp_dn", 1'b1, i);
        check("fall_bottom_ch", 32'(channel), 511);
        cyc("turn", 1'b1, 1);
        check("turn_ps", 32'(period_start), 1);
        check("turn_pc", 32'(period_count), 1);
        for (int i = 2; i <= 100; i++) cyc("climb", 1'b1, i);

        // Slope fault at 100 -> 110, then four fresh steps to relock.
        cyc("fault", 1'b1, 110);
        check("fault_se", 32'(slope_error), 1);
        for (int i = 111; i <= 120; i++) cyc("relock", 1'b1, i);

        // Descend, rise to 50 and hold 50 three times.
        for (int i = 119; i >= 48; i--) cyc("desc", 1'b1, i);
        cyc("rise49", 1'b1, 49);
        for (int k = 0; k < 3; k++) begin
            cyc("hold50", 1'b1, 50);
            check("hold50_ch", 32'(channel), 50);
        end

        // Async reset in the middle of a falling slope.
        for (int i = 49; i >= 45; i--) cyc("prefall", 1'b1, i);
        areset = 1'b1;
        #2;
        model_reset();
        check_zero("async_rst");
        @(posedge clk);
        #1;
        areset = 1'b0;
        for (int i = 45; i <= 60; i++) cyc("post_rst", 1'b1, i);

        // Invalid cycles interleaved: nothing moves, no pulses.
        for (int i = 61; i <= 90; i++) begin
            cyc("gap_v", 1'b1, i);
            for (int g = 0; g < int'($urandom_range(1, 3)); g++)
                cyc("gap_nv", 1'b0, int'($urandom_range(0, 255)));
        end

        // Tight oscillation to drive the period counter through its wrap.
        for (int k = 0; k < 600; k++) cyc("wrap", 1'b1, (k % 2 == 0) ? 89 : 90);
        check("wrap_seen", 32'(wraps_seen > 0), 1);

        // Random walk with occasional jumps, gaps and extremes.
        cur = 128;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                cyc("rnd_nv", 1'b0, int'($urandom_range(0, 255)));
            end else begin
                if ($urandom_range(0, 40) == 0) nxt = int'($urandom_range(0, 255));
                else nxt = cur + int'($urandom_range(0, 6)) - 3;
                if (nxt < 0) nxt = 0;
                if (nxt > 255) nxt = 255;
                cur = nxt;
                cyc("rnd", 1'b1, cur);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
